csr_priv_fwd_unit: RTL
======================

CSR_PRIV_FWD_UNIT -- requirements
Module: csr_priv_fwd_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, legal values 32 or 64; sets the CSR data width.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4; the maximum number of cycles a forward stays armed. 0 means it stays armed until consumed.
REQ-003 SHALL have parameter HAS_SMODE, default 1; 0 means S-mode is absent.
REQ-004 SHALL have ports `clk`, input, 1 bit (the single clock) and `reset`, input, 1 bit (asynchronous, active-high).
REQ-005 SHALL have inputs `trap_flush` (1), `trap_target_priv` (2), `mret_flush` (1) and `sret_flush` (1): trap entry and xRET commit.
REQ-006 SHALL have input `mstatus_in` (XLEN): the current architectural mstatus from the CSR file.
REQ-007 SHALL have inputs `exmem_is_mret` (1), `exmem_is_sret` (1) and `exmem_valid` (1): xRET present in MEM.
REQ-008 SHALL have inputs `idex_csr_rd` (1), `idex_valid` (1) and `idex_csr_addr` (12): CSR read in EX.
REQ-009 SHALL have inputs `exception` (1) and `ex_csr_rdata` (XLEN): the exception flag and the raw CSR read data.
REQ-010 SHALL have outputs `current_priv` (2), `effective_priv` (2), `ex_csr_rdata_fwd` (XLEN), `fwd_armed` (1) and `fwd_timeout` (1, one-cycle pulse).

Function
REQ-011 Privilege register update priority SHALL be: trap_flush sets trap_target_priv, else mret_flush sets mstatus_in.MPP, else sret_flush sets {0, SPP}.
REQ-012 When HAS_SMODE=0, sret_flush and exmem_is_sret SHALL be ignored, and trap_target_priv=01 SHALL load 11.
REQ-013 Definitions:
  - xret_mem = (exmem_is_mret | exmem_is_sret) & exmem_valid & !exception.
  - status_rd = idex_csr_rd & idex_valid & addr ∈ {0x300, 0x100}.
  - consume = status_rd & !exception.
REQ-014 FSM SHALL have states IDLE, ARM_MRET and ARM_SRET, encoded 2 bits.
REQ-015 Transition from IDLE: on xret_mem & !consume, go to ARM_MRET/ARM_SRET (MRET wins if both are flagged) and load the counter with HOLD_CYCLES. A same-cycle consume SHALL keep the FSM in IDLE.
REQ-016 Transitions from ARM_x:
  - consume goes to IDLE.
  - A new xret_mem re-arms with the new kind and reloads the counter.
  - trap_flush goes to IDLE.
  - With HOLD_CYCLES>0, the counter decrements each cycle; on reaching 1 with no consume, go to IDLE and pulse fwd_timeout.
REQ-017 FSM priority SHALL be: trap_flush > consume > new xret_mem > timeout.
REQ-018 Forwarded value when status_rd and xret_mem in the same cycle is mstatus_in modified by the xRET:
  - MRET: MIE←MPIE, MPIE←1, MPP←00.
  - SRET: SIE←SPIE, SPIE←1, SPP←0.
REQ-019 Forwarded value when status_rd in ARM_x SHALL be mstatus_in unmodified, since the CSR file is already updated.
REQ-020 When addr=0x100, the forwarded value SHALL be ANDed with SSTATUS_MASK. Otherwise ex_csr_rdata_fwd=ex_csr_rdata.
REQ-021 effective_priv SHALL equal the MRET/SRET target privilege while xret_mem, else current_priv. This path is combinational, zero latency.
REQ-022 fwd_armed SHALL be 1 exactly in ARM_MRET/ARM_SRET. The counter width SHALL be clog2(HOLD_CYCLES+1), minimum 1.
REQ-023 Bits above 31 SHALL pass through unmodified when XLEN=64.

Reset
REQ-024 Assertion of reset at any time, including mid-arm, SHALL asynchronously produce:
  - current_priv=11, FSM=IDLE, counter=0.
  - fwd_armed=0, fwd_timeout=0.
REQ-025 After reset deassertion, the first clock edge SHALL be able to arm the FSM.

Configuration
REQ-026 Macro CSR_FWD_MPRV_EN controls MPRV handling in forwarded values.
  - Defined: the MRET forward SHALL clear MPRV (bit 17) when MPP≠11, and the SRET forward SHALL clear MPRV.
  - Undefined: MPRV SHALL pass through unchanged.

Structure
REQ-027 A shared package SHALL hold:
  - the CSR addresses MSTATUS=0x300 and SSTATUS=0x100;
  - the bit indices SIE=1, MIE=3, SPIE=5, MPIE=7, SPP=8, MPP=12:11, MPRV=17;
  - SSTATUS_MASK;
  - the priv encodings PRIV_U/S/M;
  - the FSM state typedef.
REQ-028 One sub-module, xret_status_calc, SHALL be combinational: mstatus, kind → post-xRET mstatus, including the MPRV option.

Verification
REQ-029 Reset-release scenario: release reset with no events → current_priv=11, fwd_armed=0, ex_csr_rdata_fwd=ex_csr_rdata.
REQ-030 Same-cycle MRET scenario: mstatus_in=0x00001880 and MRET in MEM with a csrr mstatus in EX in the same cycle → fwd=0x00000088, FSM stays IDLE, effective_priv=11.
REQ-031 SRET-then-stall scenario:
  - Stimulus: SRET (SPP=1, SPIE=1) in MEM, then a 2-cycle stall, then a csrr sstatus.
  - Response: fwd_armed=1 for 2 cycles; the read returns mstatus_in & SSTATUS_MASK; the FSM goes to IDLE after the read; current_priv=01.
REQ-032 Timeout scenario: HOLD_CYCLES=3 and MRET with no consumer → fwd_armed high for 3 cycles, fwd_timeout pulses once, then IDLE.
REQ-033 Trap-while-armed scenario: trap_flush with target 01 while ARM_MRET, with HAS_SMODE=0 → FSM goes to IDLE and current_priv=11.
REQ-034 MPRV scenario: with CSR_FWD_MPRV_EN defined, mstatus_in=0x00020000 (MPRV=1, MPP=00) and a same-cycle MRET forward → fwd bit 17=0; with the macro undefined → fwd bit 17=1.

Source files
------------

// File: rtl/csr_priv_fwd_unit_pkg.sv
// -----------------------------------------------------------------------------
// csr_priv_fwd_unit_pkg
// Shared definitions for the CSR privilege / mstatus forwarding unit:
//   - CSR addresses for mstatus and sstatus
//   - mstatus bit positions touched by MRET/SRET
//   - SSTATUS_MASK (RV32 sstatus view of mstatus; bits above 31 are never
//     masked, so the same constant serves XLEN=64)
//   - privilege encodings
//   - forwarding FSM state type
// Optional feature macro used by importers: CSR_FWD_MPRV_EN
// -----------------------------------------------------------------------------
package csr_priv_fwd_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_SSTATUS = 12'h100;

    localparam int SIE_BIT  = 1;
    localparam int MIE_BIT  = 3;
    localparam int SPIE_BIT = 5;
    localparam int MPIE_BIT = 7;
    localparam int SPP_BIT  = 8;
    localparam int MPP_LO   = 11;
    localparam int MPP_HI   = 12;
    localparam int MPRV_BIT = 17;

    // SIE, SPIE, UBE, SPP, VS, FS, XS, SUM, MXR, SD
    localparam logic [31:0] SSTATUS_MASK = 32'h800D_E762;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM_MRET = 2'd1,
        ARM_SRET = 2'd2
    } fwd_state_t;

endpackage

// File: rtl/csr_priv_fwd_unit_xret_status_calc.sv
// -----------------------------------------------------------------------------
// xret_status_calc
// Purely combinational: computes the mstatus value an MRET or SRET will leave
// behind, so a CSR read in the same cycle as the xRET sees the new value.
// Ports:
//   mstatus      in  [XLEN]  architectural mstatus before the xRET
//   is_sret      in  1       0 = MRET, 1 = SRET
//   mstatus_post out [XLEN]  mstatus after the xRET
// Macro CSR_FWD_MPRV_EN: when defined, MPRV is cleared as on a real xRET
// (MRET only when leaving to a privilege below M); otherwise MPRV is untouched.
// -----------------------------------------------------------------------------
module xret_status_calc
    import csr_priv_fwd_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mstatus,
    input  logic            is_sret,
    output logic [XLEN-1:0] mstatus_post
);

    always_comb begin
        mstatus_post = mstatus;
        if (!is_sret) begin
            mstatus_post[MIE_BIT]       = mstatus[MPIE_BIT];
            mstatus_post[MPIE_BIT]      = 1'b1;
            mstatus_post[MPP_HI:MPP_LO] = PRIV_U;
`ifdef CSR_FWD_MPRV_EN
            if (mstatus[MPP_HI:MPP_LO] != PRIV_M) begin
                mstatus_post[MPRV_BIT] = 1'b0;
            end
`endif
        end else begin
            mstatus_post[SIE_BIT]  = mstatus[SPIE_BIT];
            mstatus_post[SPIE_BIT] = 1'b1;
            mstatus_post[SPP_BIT]  = 1'b0;
`ifdef CSR_FWD_MPRV_EN
            // SRET always returns below M, so MPRV always drops
            mstatus_post[MPRV_BIT] = 1'b0;
`endif
        end
    end

endmodule

// File: rtl/csr_priv_fwd_unit.sv
// -----------------------------------------------------------------------------
// csr_priv_fwd_unit
// Tracks the current privilege level and forwards mstatus/sstatus to a CSR
// read in EX that races with an MRET/SRET in MEM.
//   - Same cycle: the read gets mstatus_in as modified by the xRET.
//   - Later (FSM armed): the CSR file is already updated, so the read gets
//     mstatus_in unmodified. The arm expires after HOLD_CYCLES cycles
//     (0 = never expires) with a one-cycle fwd_timeout pulse.
// Ports:
//   clk, reset (async, active-high)
//   trap_flush, trap_target_priv[1:0], mret_flush, sret_flush : commit events
//   mstatus_in[XLEN]                        : architectural mstatus
//   exmem_is_mret, exmem_is_sret, exmem_valid : xRET in MEM
//   idex_csr_rd, idex_valid, idex_csr_addr[11:0] : CSR read in EX
//   exception, ex_csr_rdata[XLEN]          : exception flag, raw read data
//   current_priv[1:0], effective_priv[1:0], ex_csr_rdata_fwd[XLEN],
//   fwd_armed, fwd_timeout
// Parameters: XLEN (32/64), HOLD_CYCLES, HAS_SMODE
// Macro CSR_FWD_MPRV_EN: clear MPRV in forwarded post-xRET values.
// -----------------------------------------------------------------------------
module csr_priv_fwd_unit
    import csr_priv_fwd_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int HOLD_CYCLES = 4,
    parameter int HAS_SMODE   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            trap_flush,
    input  logic [1:0]      trap_target_priv,
    input  logic            mret_flush,
    input  logic            sret_flush,
    input  logic [XLEN-1:0] mstatus_in,
    input  logic            exmem_is_mret,
    input  logic            exmem_is_sret,
    input  logic            exmem_valid,
    input  logic            idex_csr_rd,
    input  logic            idex_valid,
    input  logic [11:0]     idex_csr_addr,
    input  logic            exception,
    input  logic [XLEN-1:0] ex_csr_rdata,
    output logic [1:0]      current_priv,
    output logic [1:0]      effective_priv,
    output logic [XLEN-1:0] ex_csr_rdata_fwd,
    output logic            fwd_armed,
    output logic            fwd_timeout
);

    localparam int              CNT_W     = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic            SMODE_EN  = (HAS_SMODE != 0);
    // Low word follows the sstatus view, upper word passes through untouched
    localparam logic [XLEN-1:0] SSTATUS_MASK_X = ~XLEN'(~SSTATUS_MASK);

    logic [1:0]       priv_reg, priv_next;
    fwd_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             timeout_reg, timeout_next;

    logic             sret_seen;
    logic             xret_mem;
    logic             status_rd;
    logic             consume;
    logic [1:0]       xret_target;
    logic [XLEN-1:0]  mstatus_post;
    logic [XLEN-1:0]  fwd_val;
    logic             use_fwd;

    assign sret_seen = exmem_is_sret & SMODE_EN;
    assign xret_mem  = (exmem_is_mret | sret_seen) & exmem_valid & ~exception;
    assign status_rd = idex_csr_rd & idex_valid &
                       ((idex_csr_addr == CSR_MSTATUS) | (idex_csr_addr == CSR_SSTATUS));
    assign consume   = status_rd & ~exception;

    // MRET takes precedence when both flags are raised
    assign xret_target = exmem_is_mret ? mstatus_in[MPP_HI:MPP_LO]
                                       : {1'b0, mstatus_in[SPP_BIT]};

    xret_status_calc #(
        .XLEN(XLEN)
    ) u_xret_calc (
        .mstatus      (mstatus_in),
        .is_sret      (~exmem_is_mret),
        .mstatus_post (mstatus_post)
    );

    // ---------------- privilege register ----------------
    always_comb begin
        priv_next = priv_reg;
        if (trap_flush) begin
            priv_next = trap_target_priv;
            // Without S-mode a trap aimed at S lands in M
            if (!SMODE_EN && (trap_target_priv == PRIV_S)) begin
                priv_next = PRIV_M;
            end
        end else if (mret_flush) begin
            priv_next = mstatus_in[MPP_HI:MPP_LO];
        end else if (sret_flush && SMODE_EN) begin
            priv_next = {1'b0, mstatus_in[SPP_BIT]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            priv_reg <= PRIV_M;
        end else begin
            priv_reg <= priv_next;
        end
    end

    // ---------------- forwarding FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        timeout_next = 1'b0;
        case (state_reg)
            IDLE: begin
                // A consumer in the same cycle already got the post-xRET
                // value, so nothing is left to arm for.
                if (!trap_flush && !consume && xret_mem) begin
                    state_next = exmem_is_mret ? ARM_MRET : ARM_SRET;
                    cnt_next   = HOLD_LOAD;
                end
            end
            ARM_MRET, ARM_SRET: begin
                if (trap_flush || consume) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (xret_mem) begin
                    state_next = exmem_is_mret ? ARM_MRET : ARM_SRET;
                    cnt_next   = HOLD_LOAD;
                end else if (HOLD_CYCLES > 0) begin
                    if (cnt_reg == CNT_W'(1)) begin
                        state_next   = IDLE;
                        cnt_next     = '0;
                        timeout_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // ---------------- read-data forwarding ----------------
    always_comb begin
        use_fwd = 1'b0;
        fwd_val = ex_csr_rdata;
        if (status_rd && xret_mem) begin
            use_fwd = 1'b1;
            fwd_val = mstatus_post;
        end else if (status_rd && (state_reg != IDLE)) begin
            use_fwd = 1'b1;
            fwd_val = mstatus_in;
        end
        if (use_fwd && (idex_csr_addr == CSR_SSTATUS)) begin
            fwd_val = fwd_val & SSTATUS_MASK_X;
        end
    end

    assign ex_csr_rdata_fwd = fwd_val;
    assign current_priv     = priv_reg;
    assign effective_priv   = xret_mem ? xret_target : priv_reg;
    assign fwd_armed        = (state_reg != IDLE);
    assign fwd_timeout      = timeout_reg;

endmodule
